// File: rtl/mem_bus_arbiter.sv
// Two-requester (A = instruction fetch, B = load/store) arbiter onto one memory-mapper port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed A priority.
module mem_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_a_req,
  input  logic        in_b_req,
  input  logic [31:0] in_a_address,
  input  logic [31:0] in_b_address,
  input  logic [31:0] in_a_data,
  input  logic [31:0] in_b_data,
  input  logic        in_a_write_en,
  input  logic        in_b_write_en,
  output logic        out_a_ready,
  output logic        out_b_ready,
  output logic        out_a_valid,
  output logic        out_b_valid,
  output logic [31:0] out_a_read_data,
  output logic [31:0] out_b_read_data,
  output logic [31:0] out_mem_address,
  output logic [31:0] out_mem_data,
  output logic        out_mem_write_en,
  input  logic [31:0] in_mem_read_data
);

  // state  | meaning
  // IDLE   | bus free; arbitrate and accept one request
  // ACCESS | drive owner's address/data (1 cycle write, READ_LATENCY cycles read)
  // RESP   | one-cycle valid pulse to the owner
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        is_write_q, is_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic        valid_a_q, valid_a_d;
  logic        valid_b_q, valid_b_d;
  logic [31:0] rdata_a_q, rdata_a_d;
  logic [31:0] rdata_b_q, rdata_b_d;
  logic        grant_a, grant_b;
  logic        tie_to_a;
  logic        last_cycle;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = B was granted last, so A takes the next tie
  logic last_b_q, last_b_d;
  assign tie_to_a = last_b_q;
`else
  assign tie_to_a = 1'b1;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE && !in_reset) begin
      if (in_a_req && in_b_req) begin
        grant_a = tie_to_a;
        grant_b = !tie_to_a;
      end else begin
        grant_a = in_a_req;
        grant_b = in_b_req;
      end
    end
  end

  assign last_cycle = is_write_q || (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    valid_a_d  = 1'b0;
    valid_b_d  = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_b_d   = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d    = ACCESS;
          cnt_d      = 2'd0;
          owner_d    = grant_b;
          is_write_d = grant_b ? in_b_write_en : in_a_write_en;
          mem_addr_d = grant_b ? in_b_address : in_a_address;
          mem_data_d = grant_b ? in_b_data : in_a_data;
          mem_we_d   = is_write_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_b_d   = grant_b;
`endif
        end
      end
      ACCESS: begin
        if (last_cycle) begin
          state_d    = RESP;
          mem_addr_d = 32'd0;
          mem_data_d = 32'd0;
          valid_a_d  = !owner_q;
          valid_b_d  = owner_q;
          if (!is_write_q) begin
            if (owner_q) rdata_b_d = in_mem_read_data;
            else         rdata_a_d = in_mem_read_data;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      owner_q    <= 1'b0;
      is_write_q <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
      mem_we_q   <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      rdata_a_q  <= 32'd0;
      rdata_b_q  <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b_q   <= last_b_d;
`endif
    end
  end

  assign out_a_ready      = grant_a;
  assign out_b_ready      = grant_b;
  assign out_a_valid      = valid_a_q;
  assign out_b_valid      = valid_b_q;
  assign out_a_read_data  = rdata_a_q;
  assign out_b_read_data  = rdata_b_q;
  assign out_mem_address  = mem_addr_q;
  assign out_mem_data     = mem_data_q;
  assign out_mem_write_en = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (READ_LATENCY 1 and 3) sharing stimulus,
// each with its own memory responder, checked against a transaction-level model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, b_req, a_we, b_we;
  logic [31:0] a_addr, b_addr, a_data, b_data;

  logic [1:0][31:0] mem_rdata;
  logic [1:0]       rdy_a, rdy_b, vld_a, vld_b, mem_we;
  logic [1:0][31:0] rd_a, rd_b, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_bus_arbiter #(.READ_LATENCY(1)) u_dut_l1 (
    .in_clk(clk), .in_reset(rst),
    .in_a_req(a_req), .in_b_req(b_req),
    .in_a_address(a_addr), .in_b_address(b_addr),
    .in_a_data(a_data), .in_b_data(b_data),
    .in_a_write_en(a_we), .in_b_write_en(b_we),
    .out_a_ready(rdy_a[0]), .out_b_ready(rdy_b[0]),
    .out_a_valid(vld_a[0]), .out_b_valid(vld_b[0]),
    .out_a_read_data(rd_a[0]), .out_b_read_data(rd_b[0]),
    .out_mem_address(mem_addr[0]), .out_mem_data(mem_wdata[0]),
    .out_mem_write_en(mem_we[0]), .in_mem_read_data(mem_rdata[0])
  );

  mem_bus_arbiter #(.READ_LATENCY(3)) u_dut_l3 (
    .in_clk(clk), .in_reset(rst),
    .in_a_req(a_req), .in_b_req(b_req),
    .in_a_address(a_addr), .in_b_address(b_addr),
    .in_a_data(a_data), .in_b_data(b_data),
    .in_a_write_en(a_we), .in_b_write_en(b_we),
    .out_a_ready(rdy_a[1]), .out_b_ready(rdy_b[1]),
    .out_a_valid(vld_a[1]), .out_b_valid(vld_b[1]),
    .out_a_read_data(rd_a[1]), .out_b_read_data(rd_b[1]),
    .out_mem_address(mem_addr[1]), .out_mem_data(mem_wdata[1]),
    .out_mem_write_en(mem_we[1]), .in_mem_read_data(mem_rdata[1])
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory responders: data presented at negedge is what the DUT samples on the next posedge
  always @(negedge clk) begin
    mem_rdata[0] = mem0.exists(mem_addr[0]) ? mem0[mem_addr[0]] : init_val(mem_addr[0]);
    mem_rdata[1] = mem1.exists(mem_addr[1]) ? mem1[mem_addr[1]] : init_val(mem_addr[1]);
    if (mem_we[0] === 1'b1) mem0[mem_addr[0]] = mem_wdata[0];
    if (mem_we[1] === 1'b1) mem1[mem_addr[1]] = mem_wdata[1];
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 32'h0038_0010; b_addr = 32'h0038_0020; a_data = 32'h1; b_data = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rdy_a[k], rdy_b[k], vld_a[k], vld_b[k], mem_we[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: rdy_a,rdy_b,vld_a,vld_b,we = %b want 00000", k,
                 {rdy_a[k], rdy_b[k], vld_a[k], vld_b[k], mem_we[k]});
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k], rd_a[k], rd_b[k]} !== 128'd0) begin
        errors++;
        $display("FAIL reset_data[%0d]: addr=%h data=%h rd_a=%h rd_b=%h want all 0", k,
                 mem_addr[k], mem_wdata[k], rd_a[k], rd_b[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({mem_addr[k], mem_we[k]} !== 33'd0) begin
        errors++;
        $display("FAIL reset_dominates[%0d]: addr=%h we=%b want 0 0", k, mem_addr[k], mem_we[k]);
      end
    end
  endtask

  task automatic test_read_a();
    int vcyc;
    logic [31:0] a1;
    do_reset();
    mem0[32'h0038_0400] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 32'h0038_0400; a_we = 1'b0; a_data = 32'h0;
    @(negedge clk);
    checks++;
    if (rdy_a[0] !== 1'b1) begin errors++; $display("FAIL read_a_ready: got %b want 1", rdy_a[0]); end
    vcyc = -1; a1 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1; a_req = 1'b0;
      @(negedge clk);
      if (i == 1) a1 = mem_addr[0];
      if (vld_a[0] === 1'b1 && vcyc < 0) vcyc = i;
    end
    checks++;
    if (a1 !== 32'h0038_0400) begin errors++; $display("FAIL read_a_addr: got %h want 00380400", a1); end
    checks++;
    if (vcyc != 2) begin errors++; $display("FAIL read_a_latency: got %0d want 2", vcyc); end
    checks++;
    if (rd_a[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_a_data: got %h want deadbeef", rd_a[0]); end
  endtask

  task automatic test_write_b();
    int vcyc, we_cnt, v_cnt;
    logic [31:0] wa, wd;
    do_reset();
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0038_0404; b_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (rdy_b[0] !== 1'b1) begin errors++; $display("FAIL write_b_ready: got %b want 1", rdy_b[0]); end
    vcyc = -1; we_cnt = 0; v_cnt = 0; wa = '0; wd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1; b_req = 1'b0; b_we = 1'b0;
      @(negedge clk);
      if (mem_we[0] === 1'b1) begin we_cnt++; wa = mem_addr[0]; wd = mem_wdata[0]; end
      if (vld_b[0] === 1'b1) begin v_cnt++; if (vcyc < 0) vcyc = i; end
    end
    checks++;
    if (we_cnt != 1) begin errors++; $display("FAIL write_b_strobe_cycles: got %0d want 1", we_cnt); end
    checks++;
    if ({wa, wd} !== {32'h0038_0404, 32'h1234_5678}) begin
      errors++; $display("FAIL write_b_bus: addr=%h data=%h want 00380404 12345678", wa, wd);
    end
    checks++;
    if (vcyc != 2 || v_cnt != 1) begin
      errors++; $display("FAIL write_b_valid: first at %0d count %0d want 2 and 1", vcyc, v_cnt);
    end
  endtask

  task automatic test_tie();
    int g[4];
    int gc[4];
    int n, both, expg;
    do_reset();
    @(posedge clk); #1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 32'h0038_0100; b_addr = 32'h0038_0200;
    n = 0; both = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (rdy_a[0] === 1'b1 && rdy_b[0] === 1'b1) both++;
      if (rdy_a[0] === 1'b1) begin g[n] = 0; gc[n] = i; n++; end
      else if (rdy_b[0] === 1'b1) begin g[n] = 1; gc[n] = i; n++; end
      @(posedge clk); #1;
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (n != 4 || both != 0) begin
      errors++; $display("FAIL tie_grants: got %0d grants, %0d double, want 4 and 0", n, both);
    end
    for (int j = 0; j < n; j++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expg = j % 2;
`else
      expg = 0;
`endif
      checks++;
      if (g[j] != expg) begin errors++; $display("FAIL tie_order[%0d]: got %s want %s", j, g[j] ? "B" : "A", expg ? "B" : "A"); end
      if (j > 0) begin
        checks++;
        if (gc[j] - gc[j-1] != 3) begin errors++; $display("FAIL tie_spacing[%0d]: got %0d want 3", j, gc[j] - gc[j-1]); end
      end
    end
  endtask

  task automatic test_lat3();
    int vcyc;
    logic [31:0] x;
    x = 32'h0038_0800;
    do_reset();
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = x; a_we = 1'b0; a_data = 32'h0; mem1[x] = 32'h1111_0000;
    @(negedge clk);
    checks++;
    if (rdy_a[1] !== 1'b1) begin errors++; $display("FAIL lat3_ready: got %b want 1", rdy_a[1]); end
    vcyc = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      a_req = 1'b0; mem1[x] = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      if (i <= 3) begin
        checks++;
        if (mem_addr[1] !== x) begin errors++; $display("FAIL lat3_addr_c%0d: got %h want %h", i, mem_addr[1], x); end
      end
      if (i == 4) begin
        checks++;
        if (mem_addr[1] !== 32'd0) begin errors++; $display("FAIL lat3_addr_release: got %h want 0", mem_addr[1]); end
      end
      if (vld_a[1] === 1'b1 && vcyc < 0) vcyc = i;
    end
    checks++;
    if (vcyc != 4) begin errors++; $display("FAIL lat3_latency: got %0d want 4", vcyc); end
    checks++;
    if (rd_a[1] !== 32'h1111_0003) begin errors++; $display("FAIL lat3_sample: got %h want 11110003", rd_a[1]); end
  endtask

  task automatic test_reset_mid();
    int bad_valid;
    do_reset();
    mem1[32'h0038_0C00] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 32'h0038_0C00; a_we = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1; a_req = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (rd_a[1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_prime: got %h want cafef00d", rd_a[1]); end
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 32'h0038_0C04;
    @(negedge clk);
    checks++;
    if (rdy_a[1] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", rdy_a[1]); end
    @(posedge clk); #1; a_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0038_0C08;
    @(negedge clk);
    checks++;
    if ({rdy_b[1], vld_a[1]} !== 2'b10) begin
      errors++; $display("FAIL rstmid_idle: rdy_b=%b vld_a=%b want 1 0", rdy_b[1], vld_a[1]);
    end
    checks++;
    if ({mem_addr[1], rd_a[1]} !== 64'd0) begin
      errors++; $display("FAIL rstmid_clear: addr=%h rd_a=%h want 0 0", mem_addr[1], rd_a[1]);
    end
    bad_valid = 0;
    for (int i = 4; i <= 8; i++) begin
      @(posedge clk); #1; b_req = 1'b0;
      @(negedge clk);
      if (vld_a[1] === 1'b1) bad_valid++;
    end
    checks++;
    if (bad_valid != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", bad_valid); end
  endtask

  task automatic test_wait();
    int rcyc, rcnt, vcyc;
    do_reset();
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0038_0300;
    @(negedge clk);
    checks++;
    if (rdy_a[0] !== 1'b1) begin errors++; $display("FAIL wait_a_ready: got %b want 1", rdy_a[0]); end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0038_0304; b_data = 32'h0BAD_F00D;
    rcyc = -1; rcnt = 0; vcyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rdy_b[0] === 1'b1) begin rcnt++; if (rcyc < 0) rcyc = i; end
      if (vld_b[0] === 1'b1 && vcyc < 0) vcyc = i;
      @(posedge clk); #1;
      if (rcyc >= 0) b_req = 1'b0;
    end
    checks++;
    if (rcyc != 3 || rcnt != 1) begin
      errors++; $display("FAIL wait_b_accept: first at %0d count %0d want 3 and 1", rcyc, rcnt);
    end
    checks++;
    if (vcyc != 5) begin errors++; $display("FAIL wait_b_valid: got %0d want 5", vcyc); end
  endtask

  // Transaction-level reference: a grant occupies the bus for lat+2 cycles
  // (lat = 1 for writes); address visible for lat cycles, valid at lat+1.
  task automatic test_random(input int k, input int n_cycles);
    int lat, free_at, acc_t, tx_lat;
    logic tx_act, tx_owner, tx_we, last_b, acc_a, acc_b;
    logic exp_ra, exp_rb, exp_we, exp_va, exp_vb;
    logic [31:0] tx_addr, tx_wdata, tx_rdata, exp_addr, exp_wd;
    logic [1:0][31:0] exp_rd;
    lat = (k == 0) ? 1 : 3;
    do_reset();
    if (k == 0) mem0.delete(); else mem1.delete();
    ref_mem.delete();
    free_at = 0; acc_t = 0; tx_lat = 1; tx_act = 1'b0; tx_owner = 1'b0; tx_we = 1'b0;
    tx_addr = '0; tx_wdata = '0; tx_rdata = '0; exp_rd = '0; last_b = 1'b1;
    acc_a = 1'b0; acc_b = 1'b0;
    for (int t = 0; t < n_cycles; t++) begin
      @(posedge clk); #1;
      if (acc_a || a_req !== 1'b1) begin
        if ($urandom_range(0, 3) != 0) begin
          a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
          a_addr = 32'h0038_0400 + ($urandom_range(0, 15) << 2); a_data = $urandom;
        end else a_req = 1'b0;
      end
      if (acc_b || b_req !== 1'b1) begin
        if ($urandom_range(0, 3) != 0) begin
          b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
          b_addr = 32'h0038_0400 + ($urandom_range(0, 15) << 2); b_data = $urandom;
        end else b_req = 1'b0;
      end
      @(negedge clk);
      exp_ra = 1'b0; exp_rb = 1'b0;
      if (t >= free_at) begin
        if (a_req && b_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          exp_rb = !last_b;
`else
          exp_rb = 1'b0;
`endif
          exp_ra = !exp_rb;
        end else begin
          exp_ra = a_req; exp_rb = b_req;
        end
      end
      exp_addr = '0; exp_wd = '0; exp_we = 1'b0; exp_va = 1'b0; exp_vb = 1'b0;
      if (tx_act) begin
        if (t >= acc_t + 1 && t <= acc_t + tx_lat) begin
          exp_addr = tx_addr; exp_wd = tx_wdata; exp_we = tx_we && (t == acc_t + 1);
        end
        if (t == acc_t + tx_lat + 1) begin
          if (tx_owner) exp_vb = 1'b1; else exp_va = 1'b1;
          if (!tx_we) exp_rd[tx_owner] = tx_rdata;
        end
      end
      checks++;
      if ({rdy_a[k], rdy_b[k]} !== {exp_ra, exp_rb}) begin
        errors++; $display("FAIL rnd%0d_ready t=%0d: got %b%b want %b%b", k, t, rdy_a[k], rdy_b[k], exp_ra, exp_rb);
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k], mem_we[k]} !== {exp_addr, exp_wd, exp_we}) begin
        errors++; $display("FAIL rnd%0d_bus t=%0d: got %h %h %b want %h %h %b", k, t,
                           mem_addr[k], mem_wdata[k], mem_we[k], exp_addr, exp_wd, exp_we);
      end
      checks++;
      if ({vld_a[k], vld_b[k]} !== {exp_va, exp_vb}) begin
        errors++; $display("FAIL rnd%0d_valid t=%0d: got %b%b want %b%b", k, t, vld_a[k], vld_b[k], exp_va, exp_vb);
      end
      checks++;
      if ({rd_a[k], rd_b[k]} !== {exp_rd[0], exp_rd[1]}) begin
        errors++; $display("FAIL rnd%0d_rdata t=%0d: got %h %h want %h %h", k, t, rd_a[k], rd_b[k], exp_rd[0], exp_rd[1]);
      end
      if (exp_ra || exp_rb) begin
        tx_act = 1'b1; acc_t = t; tx_owner = exp_rb;
        tx_we    = exp_rb ? b_we : a_we;
        tx_addr  = exp_rb ? b_addr : a_addr;
        tx_wdata = exp_rb ? b_data : a_data;
        tx_lat   = tx_we ? 1 : lat;
        free_at  = t + tx_lat + 2;
        last_b   = tx_owner;
        if (tx_we) ref_mem[tx_addr] = tx_wdata;
        else tx_rdata = ref_mem.exists(tx_addr) ? ref_mem[tx_addr] : init_val(tx_addr);
      end
      acc_a = (rdy_a[k] === 1'b1);
      acc_b = (rdy_b[k] === 1'b1);
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    test_reset();
    test_read_a();
    test_write_b();
    test_tie();
    test_lat3();
    test_reset_mid();
    test_wait();
    test_random(0, 500);
    test_random(1, 500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
